// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter between the CPU
// Memory stage and the external debug/DMA port.
package dmem_arb_pkg;

    localparam int DEF_ADDR_W   = 10;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_MAX_WAIT = 4;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } arb_state_t;

    // Counter must hold 0..max_wait; keep at least one bit so MAX_WAIT=0 still elaborates.
    function automatic int wait_cnt_w(input int max_wait);
        return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/dmem_wait_ctr.sv
// Saturating wait counter: counts denied EXT cycles and flags when the
// forced-grant threshold is reached.
module dmem_wait_ctr
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int W = wait_cnt_w(MAX_WAIT);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign sat = (cnt_q == W'(MAX_WAIT));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !sat) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU has priority, EXT port is guaranteed
// service within MAX_WAIT+1 cycles and stalls the pipeline when it wins.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_ack,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    arb_state_t        state_q;
    logic              ext_ack_q;
    logic [DATA_W-1:0] ext_rdata_q;

    logic cpu_acc;
    logic wait_sat;
    logic ext_grant;
    logic ctr_inc;
    logic ctr_clr;
    logic in_idle;

    assign cpu_acc   = cpu_rd | cpu_wr;
    assign in_idle   = (state_q == IDLE);
    assign ext_grant = !rst && in_idle && ext_req && (!cpu_acc || wait_sat);

    assign ctr_inc = in_idle && !ext_grant && ext_req && cpu_acc;
    assign ctr_clr = in_idle && (ext_grant || !ext_req);

    dmem_wait_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_ctr (
        .clk (clk),
        .rst (rst),
        .inc (ctr_inc),
        .clr (ctr_clr),
        .sat (wait_sat)
    );

    // A stalled CPU store is simply not issued; the pipeline re-presents it.
    always_comb begin
        if (ext_grant) begin
            mem_we   = ext_we;
            mem_addr = ext_addr;
            mem_din  = ext_wdata;
        end else begin
            mem_we   = cpu_wr & !rst;
            mem_addr = cpu_addr;
            mem_din  = cpu_wdata;
        end
    end

    assign cpu_stall = ext_grant & cpu_acc;
    assign cpu_rdata = mem_dout;
    assign ext_ack   = ext_ack_q;
    assign ext_rdata = ext_rdata_q;

    // ACK always returns to IDLE so a still-held request is not serviced twice.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ext_ack_q   <= 1'b0;
            ext_rdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ext_grant) begin
                        state_q   <= ACK;
                        ext_ack_q <= 1'b1;
                        if (!ext_we) begin
                            ext_rdata_q <= mem_dout;
                        end
                    end
                end
                ACK: begin
                    state_q   <= IDLE;
                    ext_ack_q <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    ext_ack_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 1K x 32 data memory between the pipeline Memory stage (CPU port) and an external debug/DMA port (EXT port).
- CPU has priority by default. A bounded-wait counter guarantees the EXT port service within MAX_WAIT+1 cycles of its request.
- When EXT wins a cycle in which the CPU also wants memory, the block stalls the pipeline.
- Sits between the Memory stage memory-control signals and the data_memory instance.

Parameters:
- ADDR_W, 10, word address width into data memory.
- DATA_W, 32, data width.
- MAX_WAIT, 4, max consecutive cycles a pending EXT request is denied before forced grant; 0 = EXT always wins.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cpu_rd  in  1  Memory stage load this cycle
- cpu_wr  in  1  Memory stage store this cycle (MemWrite)
- cpu_addr  in  ADDR_W  CPU word address (ALUResult[9:0])
- cpu_wdata  in  DATA_W  CPU store data
- cpu_rdata  out  DATA_W  CPU load data (combinational from mem_dout)
- cpu_stall  out  1  pipeline must hold Memory stage and upstream this cycle
- ext_req  in  1  EXT request, level, held until ext_ack
- ext_we  in  1  EXT write (1) / read (0)
- ext_addr  in  ADDR_W  EXT address
- ext_wdata  in  DATA_W  EXT write data
- ext_ack  out  1  one-cycle completion pulse, registered
- ext_rdata  out  DATA_W  EXT read data, registered, valid with ext_ack
- mem_we  out  1  data memory W_EN
- mem_addr  out  ADDR_W  data memory ADDR
- mem_din  out  DATA_W  data memory D_IN
- mem_dout  in  DATA_W  data memory D_OUT (combinational read, write on clk rising edge)

Behaviour:
- Signal definitions:
  - cpu_acc = cpu_rd | cpu_wr. cpu_rd & cpu_wr together is treated as a write.
  - ext_grant (comb) = !rst & state==IDLE & ext_req & (!cpu_acc | wait_cnt==MAX_WAIT).
- Mux:
  - ext_grant=1: mem_we=ext_we, mem_addr=ext_addr, mem_din=ext_wdata.
  - ext_grant=0: mem_we=cpu_wr & !rst, mem_addr=cpu_addr, mem_din=cpu_wdata.
- cpu_stall = ext_grant & cpu_acc. While stalled, the CPU write is not issued; the CPU re-presents the same access next cycle.
- cpu_rdata = mem_dout every cycle; the pipeline uses it only when cpu_stall=0.
- FSM states: IDLE, ACK.
  - IDLE with ext_grant -> ACK. Registers ext_ack<=1. ext_rdata<=mem_dout if !ext_we, else hold. wait_cnt<=0.
  - IDLE with no grant: stay in IDLE.
    - If ext_req & cpu_acc: wait_cnt<=min(wait_cnt+1, MAX_WAIT).
    - If !ext_req: wait_cnt<=0.
  - ACK -> IDLE unconditionally; ext_ack<=0. No EXT grant in ACK, even with ext_req still high, so a held request is never double-serviced. The CPU owns memory in ACK.
- Latency:
  - EXT access completes on the grant edge; ack is visible the cycle after the grant.
  - Minimum 1 cycle request-to-ack when the CPU is idle.
  - Maximum MAX_WAIT+1 cycles with the CPU continuously busy.
- Back-to-back EXT requests are served at most every 2 cycles.
- wait_cnt width is $clog2(MAX_WAIT+1), minimum 1 bit. It saturates and never wraps.
- ext_req dropped before grant: no access, wait_cnt clears, no ack.
- Reset values: state=IDLE, ext_ack=0, ext_rdata=0, wait_cnt=0. While rst=1: mem_we=0, cpu_stall=0, ext_grant=0.
- Reset asserted in ACK: ext_ack deasserts at the reset edge.

Decomposition:
- Package dmem_arb_pkg:
  - typedef enum logic {IDLE, ACK} arb_state_t
  - ADDR_W / DATA_W defaults
- Optional sub-module dmem_wait_ctr: saturating counter with inc/clr/sat outputs. The mux and FSM stay in dmem_arbiter.
- The Memory stage instantiates dmem_arbiter in front of data_memory. The pipeline hazard unit consumes cpu_stall.

Test Plan:
- CPU only: cpu_wr addr 0x010 data 0xDEADBEEF, then cpu_rd 0x010 -> cpu_rdata=0xDEADBEEF, cpu_stall never 1, ext_ack never 1.
- EXT only: ext_req write 0x3FF=0x12345678, then read 0x3FF -> each ack 1 cycle after req, ext_rdata=0x12345678, a 1-cycle ACK gap between them, req held high not double-serviced.
- Contention, MAX_WAIT=4: cpu_rd every cycle, ext_req read at cycle 0 -> denied cycles 0-3, grant at cycle 4 with cpu_stall=1 only at cycle 4, ext_ack at cycle 5.
- Stalled store: cpu_wr 0x020=0xAAAA5555 coincides with forced EXT read of 0x020 (old value 0x1) -> ext_rdata=0x1, memory unchanged that cycle, store lands next cycle, CPU read returns 0xAAAA5555.
- Abort: ext_req high 2 cycles under CPU load then low -> no ack, wait_cnt returns to 0, memory untouched.
- Reset mid-op: assert rst during ACK with cpu_wr=1 -> ext_ack=0 and ext_rdata=0 after edge, mem_we=0 and cpu_stall=0 while rst high.
